// File: rtl/calc_sequencer.sv
// Operand-load / add / display sequencer driving an external 3-bit adder.
// Operands A and B are loaded from the switches. A go strobe latches the adder sum.
// The sum is then shown for a fixed number of slow ticks before the block returns to idle.
module calc_sequencer #(
    parameter int unsigned SHOW_TICKS    = 8,
    parameter int unsigned TIMEOUT_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_go,
    input  logic       btn_clr,
    input  logic [2:0] sw_val,
    input  logic       tick,
    input  logic [3:0] sum_in,
    output logic [2:0] op_a,
    output logic [2:0] op_b,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic [7:0] led
);

    localparam int unsigned CNT_MAX = (SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HAVE_A = 3'd1,
        READY  = 3'd2,
        CALC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          blink;

    logic do_clr;
    logic do_go;
    logic do_a;
    logic do_b;
    logic timeout_last;
    logic show_last;

    // Resolve simultaneous strobes: clr > go > a > b
    assign do_clr = btn_clr;
    assign do_go  = btn_go & ~btn_clr;
    assign do_a   = btn_a & ~btn_go & ~btn_clr;
    assign do_b   = btn_b & ~btn_a & ~btn_go & ~btn_clr;

    // The shared tick counter is cleared on every state entry that uses it
    assign timeout_last = (cnt == CW'(TIMEOUT_TICKS - 1));
    assign show_last    = (cnt == CW'(SHOW_TICKS - 1));

    // Sequencer state, operands, result and tick counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            cnt          <= '0;
            blink        <= 1'b0;
        end else if (do_clr) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            cnt          <= '0;
            blink        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_a) begin
                        op_a         <= sw_val;
                        result       <= '0;
                        result_valid <= 1'b0;
                        cnt          <= '0;
                        state        <= HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (do_a) begin
                        op_a <= sw_val;
                        cnt  <= '0;
                    end else if (do_b) begin
                        op_b  <= sw_val;
                        cnt   <= '0;
                        state <= READY;
                    end else if (tick) begin
                        if (timeout_last) begin
                            op_a  <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                READY: begin
                    if (do_go) begin
                        state <= CALC;
                    end else if (do_a) begin
                        op_a <= sw_val;
                    end else if (do_b) begin
                        op_b <= sw_val;
                    end
                end
                CALC: begin
                    result       <= sum_in;
                    result_valid <= 1'b1;
                    cnt          <= '0;
                    blink        <= 1'b1;
                    state        <= SHOW;
                end
                SHOW: begin
                    if (tick) begin
                        if (show_last) begin
                            cnt   <= '0;
                            blink <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt   <= cnt + CW'(1);
                            blink <= ~blink;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from registered state only
    always_comb begin
        busy = 1'b0;
        led  = {2'b00, op_a, op_b};
        case (state)
            CALC: begin
                busy = 1'b1;
                led  = 8'h00;
            end
            SHOW: begin
                busy = 1'b1;
                led  = {blink, 3'b000, result};
            end
            default: begin
                busy = 1'b0;
                led  = {2'b00, op_a, op_b};
            end
        endcase
    end

endmodule
